shift_seq_counter: RTL and testbench

- Parametrised ring/Johnson shift counter with run-time mode and direction, parallel load, and illegal-state detection with self-correction.
- Produces the raw state, a binary phase index, a one-hot phase decode, and wrap and error pulses.
- Used as a sequence and phase generator for strobe, mux-select and stepper-style drive logic.

---
 rtl/shift_seq_counter.sv | 165 ++++++++++++++++
 tb/tb_shift_seq_counter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_counter.sv
// Ring / Johnson shift counter with run-time mode and direction, parallel load,
// and illegal-state detection that repairs the state on the next enabled edge.
module shift_seq_counter #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 dir,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     q,
    output logic [IW-1:0]        idx,
    output logic [2*WIDTH-1:0]   dec,
    output logic                 illegal,
    output logic                 wrap,
    output logic                 err
);

    localparam logic [IW:0]      TWO_N     = (IW + 1)'(2 * WIDTH);
    localparam logic [IW-1:0]    RING_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    JOHN_LAST = IW'(2 * WIDTH - 1);
    localparam logic [WIDTH-1:0] RING_SEED = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};

    function automatic logic [IW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IW:0] c;
        c = (IW + 1)'(0);
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IW + 1)'(v[i]);
        end
        return c;
    endfunction

    function automatic logic ring_legal(input logic [WIDTH-1:0] v);
        return popcount(v) == (IW + 1)'(1);
    endfunction

    // Johnson states have at most one boundary between adjacent bits (linear, not circular).
    function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
        logic [IW:0] t;
        t = (IW + 1)'(0);
        for (int i = 0; i < WIDTH - 1; i++) begin
            t = t + (IW + 1)'(v[i] ^ v[i+1]);
        end
        return t <= (IW + 1)'(1);
    endfunction

    function automatic logic [IW-1:0] ring_pos(input logic [WIDTH-1:0] v);
        logic [IW-1:0] p;
        p = IW'(0);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                p = IW'(i);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    function automatic logic [IW-1:0] johnson_pos(input logic [WIDTH-1:0] v);
        logic [IW:0] pc;
        pc = popcount(v);
        if ((v == ALL_ZERO) || v[0]) begin
            return IW'(pc);
        end else begin
            return IW'(TWO_N - pc);
        end
    endfunction

    function automatic logic [WIDTH-1:0] ring_step(input logic [WIDTH-1:0] v, input logic d);
        if (d) begin
            return {v[0], v[WIDTH-1:1]};
        end else begin
            return {v[WIDTH-2:0], v[WIDTH-1]};
        end
    endfunction

    function automatic logic [WIDTH-1:0] johnson_step(input logic [WIDTH-1:0] v, input logic d);
        if (d) begin
            return {~v[0], v[WIDTH-1:1]};
        end else begin
            return {v[WIDTH-2:0], ~v[WIDTH-1]};
        end
    endfunction

    logic [WIDTH-1:0]   q_q, q_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               legal_s;
    logic [IW-1:0]      idx_s;
    logic [IW-1:0]      last_idx_s;
    logic [2*WIDTH-1:0] dec_s;

    // Phase decode of the current state under the current mode.
    always_comb begin
        legal_s    = 1'b0;
        idx_s      = IW'(0);
        last_idx_s = RING_LAST;
        dec_s      = {(2 * WIDTH){1'b0}};
        if (mode) begin
            legal_s    = johnson_legal(q_q);
            last_idx_s = JOHN_LAST;
        end else begin
            legal_s    = ring_legal(q_q);
            last_idx_s = RING_LAST;
        end
        if (!legal_s) begin
            idx_s = IW'(0);
        end else if (mode) begin
            idx_s = johnson_pos(q_q);
        end else begin
            idx_s = ring_pos(q_q);
        end
        if (legal_s) begin
            dec_s = (2 * WIDTH)'(1) << idx_s;
        end else begin
            dec_s = {(2 * WIDTH){1'b0}};
        end
    end

    // Next state: load beats correction, correction beats step, otherwise hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (!legal_s) begin
                q_d   = mode ? ALL_ZERO : RING_SEED;
                err_d = 1'b1;
            end else begin
                q_d    = mode ? johnson_step(q_q, dir) : ring_step(q_q, dir);
                wrap_d = dir ? (idx_s == IW'(0)) : (idx_s == last_idx_s);
            end
        end else begin
            q_d = q_q;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= ALL_ZERO;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q       = q_q;
    assign idx     = idx_s;
    assign dec     = dec_s;
    assign illegal = ~legal_s;
    assign wrap    = wrap_q;
    assign err     = err_q;

endmodule

// File: tb/tb_shift_seq_counter.sv
// Self-checking bench for shift_seq_counter (WIDTH=4): directed scenarios plus
// randomized traffic against a phase-table reference model.
module tb_shift_seq_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [2:0] idx;
    logic [7:0] dec;
    logic       illegal;
    logic       wrap;
    logic       err;

    int tests_run;
    int tests_failed;

    // Reference model state
    logic [3:0] mq;
    logic       mwrap;
    logic       merr;

    shift_seq_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .q(q), .idx(idx), .dec(dec),
        .illegal(illegal), .wrap(wrap), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal state for phase k of the sequence in mode m.
    function automatic logic [3:0] phase_state(input logic m, input int k);
        int v;
        if (!m) begin
            v = 1 << k;
        end else if (k <= 4) begin
            v = (1 << k) - 1;
        end else begin
            v = 15 - ((1 << (k - 4)) - 1);
        end
        return v[3:0];
    endfunction

    function automatic int period(input logic m);
        return m ? 8 : 4;
    endfunction

    function automatic int find_phase(input logic [3:0] v, input logic m);
        for (int k = 0; k < period(m); k++) begin
            if (phase_state(m, k) == v) return k;
        end
        return -1;
    endfunction

    function automatic logic [17:0] exp_vec();
        int ph;
        logic [2:0] ei;
        logic [7:0] ed;
        ph = find_phase(mq, mode);
        ei = (ph < 0) ? 3'd0 : 3'(ph);
        ed = (ph < 0) ? 8'd0 : (8'd1 << ph);
        return {mq, ei, ed, (ph < 0), mwrap, merr};
    endfunction

    function automatic logic [17:0] got_vec();
        return {q, idx, dec, illegal, wrap, err};
    endfunction

    task automatic model_reset();
        mq = 4'd0; mwrap = 1'b0; merr = 1'b0;
    endtask

    // Advance the model with the current inputs, then clock the DUT and settle.
    task automatic tick();
        int ph, nph, p;
        ph = find_phase(mq, mode);
        p  = period(mode);
        mwrap = 1'b0; merr = 1'b0;
        if (load) begin
            mq = load_val;
        end else if (en) begin
            if (ph < 0) begin
                mq = mode ? 4'd0 : 4'd1;
                merr = 1'b1;
            end else begin
                nph = dir ? (ph + p - 1) % p : (ph + 1) % p;
                mq = phase_state(mode, nph);
                mwrap = dir ? (ph == 0) : (ph == p - 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
        model_reset();
        #1;
        tests_run++;
        if (got_vec() !== exp_vec() || illegal !== 1'b1 || dec !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_ring: got %h expected %h", got_vec(), exp_vec());
        end
        mode = 1'b1;
        #1;
        tests_run++;
        if (got_vec() !== exp_vec() || illegal !== 1'b0 || idx !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_johnson: got %h expected %h", got_vec(), exp_vec());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_johnson_up();
        logic [3:0] seq [8];
        seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        mode = 1'b1; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (got_vec() !== exp_vec() || q !== seq[i] || wrap !== (i == 7)
                || dec !== (8'd1 << idx)) begin
                tests_failed++;
                $display("FAIL johnson_up step %0d: got %h expected %h (q want %b)",
                         i, got_vec(), exp_vec(), seq[i]);
            end
        end
    endtask

    task automatic test_ring_recovery();
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        en = 1'b0; mode = 1'b0; dir = 1'b0;
        rst = 1'b1; model_reset(); #1; rst = 1'b0; #1;
        tests_run++;
        if (illegal !== 1'b1 || dec !== 8'd0) begin
            tests_failed++;
            $display("FAIL ring_recovery_illegal: got ill=%b dec=%h expected ill=1 dec=00", illegal, dec);
        end
        en = 1'b1;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0001 || err !== 1'b1 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL ring_recovery_fix: got %h expected %h", got_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (got_vec() !== exp_vec() || q !== seq[i] || wrap !== (i == 3) || err !== 1'b0) begin
                tests_failed++;
                $display("FAIL ring_recovery step %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ring_down_wrap();
        mode = 1'b0; dir = 1'b1; en = 1'b1;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b1000 || idx !== 3'd3 || wrap !== 1'b1) begin
            tests_failed++;
            $display("FAIL ring_down_wrap: got %h expected %h", got_vec(), exp_vec());
        end
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0100 || idx !== 3'd2 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL ring_down_next: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_load_correction();
        mode = 1'b1; dir = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'b0110;
        tick();
        load = 1'b0;
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0110 || illegal !== 1'b1 || dec !== 8'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_capture: got %h expected %h", got_vec(), exp_vec());
        end
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0000 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_correct: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_mode_switch_hold();
        mode = 1'b1; dir = 1'b0; en = 1'b1;
        tick(); tick();
        mode = 1'b0; en = 1'b0;
        #1;
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0011 || illegal !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_switch_illegal: got %h expected %h", got_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (got_vec() !== exp_vec() || q !== 4'b0011 || err !== 1'b0) begin
                tests_failed++;
                $display("FAIL mode_switch_hold %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        en = 1'b1;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0001 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_switch_fix: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b1; dir = 1'b0; en = 1'b1;
        rst = 1'b1; model_reset(); #1; rst = 1'b0;
        @(negedge clk);
        tick(); tick(); tick();
        tests_run++;
        if (q !== 4'b0111) begin
            tests_failed++;
            $display("FAIL async_reset_pre: got q=%b expected 0111", q);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'd0 || wrap !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_clear: got %h expected %h", got_vec(), exp_vec());
        end
        #1;
        rst = 1'b0;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || q !== 4'b0001) begin
            tests_failed++;
            $display("FAIL async_reset_resume: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            tick();
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random step %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        load = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_johnson_up();
        test_ring_recovery();
        test_ring_down_wrap();
        test_load_correction();
        test_mode_switch_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
